game_lfsr_rng: RTL and testbench

- Parametrised Galois LFSR random source for game logic: configurable width, tap polynomial and seed, with run-time enable, reseed and zero-lockup recovery.
- Adds a req/valid "random below limit" service.
  - Uses masked rejection sampling with a bounded retry count.
  - Game FSMs (spawn positions, directions, delays) get uniformly distributed values in [0, limit) without their own modulo logic.

---
 rtl/game_lfsr_rng.sv | 130 +++++++++++++
 tb/tb_game_lfsr_rng.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/game_lfsr_rng.sv
// Galois LFSR random source with a req/valid "random below limit" service using masked rejection sampling.
// Optional advance counter on step_count is built when GAME_LFSR_RNG_STEP_COUNT_EN is defined.
module game_lfsr_rng #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(16'h100B),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(16'h1FFF),
  parameter int              OUT_W     = 8,
  parameter int              MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] random,
  input  logic             req,
  input  logic [OUT_W-1:0] limit,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] value,
  output logic [31:0]      step_count
);

  // Handshake: req is taken only in IDLE (busy=0, valid=0); busy covers SAMPLE;
  // valid pulses for exactly one cycle in DONE and value holds between pulses.
  typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_t;
  state_t fsm_state;

  logic [OUT_W-1:0] lim;
  logic [OUT_W-1:0] mask;
  logic [7:0]       tries;
  logic [WIDTH-1:0] step_next;
  logic [OUT_W-1:0] cand;
  logic             sampling;
  logic             advance;

  // Smallest all-ones pattern covering lim-1, so a masked candidate is below 2*lim.
  function automatic logic [OUT_W-1:0] mask_of(input logic [OUT_W-1:0] l);
    logic [OUT_W-1:0] m;
    m = l - OUT_W'(1);
    for (int i = 1; i < OUT_W; i++) m = m | (m >> i);
    return m;
  endfunction

  assign step_next = {random[WIDTH-2:0], 1'b0} ^ (random[WIDTH-1] ? TAPS : '0);
  assign cand      = random[OUT_W-1:0] & mask;
  // A zero limit passes through SAMPLE without consuming LFSR state.
  assign sampling  = (fsm_state == SAMPLE) && (lim != '0);
  assign advance   = !load && (enable || sampling);

  always_ff @(posedge clk) begin
    if (reset) begin
      random <= SEED;
    end else if (load) begin
      random <= (load_value == '0) ? SEED : load_value;
    end else if (advance) begin
      random <= step_next;
    end
  end

`ifdef GAME_LFSR_RNG_STEP_COUNT_EN
  logic [31:0] step_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt <= '0;
    end else if (advance) begin
      step_cnt <= step_cnt + 32'd1;
    end
  end
  assign step_count = step_cnt;
`else
  assign step_count = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_state <= IDLE;
      busy      <= 1'b0;
      valid     <= 1'b0;
      value     <= '0;
      lim       <= '0;
      mask      <= '0;
      tries     <= '0;
    end else begin
      case (fsm_state)
        IDLE: begin
          valid <= 1'b0;
          if (req) begin
            lim       <= limit;
            mask      <= mask_of(limit);
            tries     <= '0;
            busy      <= 1'b1;
            fsm_state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (lim == '0) begin
            value     <= '0;
            busy      <= 1'b0;
            valid     <= 1'b1;
            fsm_state <= DONE;
          end else if (cand < lim) begin
            value     <= cand;
            busy      <= 1'b0;
            valid     <= 1'b1;
            fsm_state <= DONE;
          end else if (tries == 8'(MAX_TRIES - 1)) begin
            // mask < 2*lim, so cand - lim is already in range.
            value     <= cand - lim;
            busy      <= 1'b0;
            valid     <= 1'b1;
            fsm_state <= DONE;
          end else begin
            tries <= tries + 8'd1;
          end
        end
        DONE: begin
          valid     <= 1'b0;
          fsm_state <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          valid     <= 1'b0;
          fsm_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_lfsr_rng.sv
// Directed bench for game_lfsr_rng: stepping, reseed, bounded requests, fallback, abort and advance counting.
module tb_game_lfsr_rng;

  logic        clk = 1'b0;
  logic        reset, enable, load, req;
  logic [15:0] load_value;
  logic [7:0]  limit;
  logic [15:0] random, random2;
  logic        busy, valid, busy2, valid2;
  logic [7:0]  value, value2;
  logic [31:0] step_count, step_count2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  game_lfsr_rng u_dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_value(load_value),
    .random(random), .req(req), .limit(limit), .busy(busy), .valid(valid),
    .value(value), .step_count(step_count)
  );

  game_lfsr_rng #(.MAX_TRIES(1)) u_dut_fb (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_value(load_value),
    .random(random2), .req(req), .limit(limit), .busy(busy2), .valid(valid2),
    .value(value2), .step_count(step_count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_state(input logic [15:0] v);
    load = 1'b1; load_value = v;
    tick();
    load = 1'b0; load_value = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; load = 1'b0; load_value = '0; req = 1'b0; limit = '0;
    tick(); tick();
    checks++; if (random !== 16'h1FFF) begin failures++; $display("FAIL reset_random got=%h exp=1fff", random); end
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin failures++; $display("FAIL reset_flags busy=%b valid=%b exp=0,0", busy, valid); end
    checks++; if (value !== 8'h00) begin failures++; $display("FAIL reset_value got=%h exp=00", value); end
    checks++; if (step_count !== 32'd0) begin failures++; $display("FAIL reset_step_count got=%0d exp=0", step_count); end
    reset = 1'b0;
  endtask

  task automatic test_step();
    logic [15:0] exp_seq [4] = '{16'h3FFE, 16'h7FFC, 16'hFFF8, 16'hEFFB};
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (random !== exp_seq[i]) begin failures++; $display("FAIL step_%0d got=%h exp=%h", i, random, exp_seq[i]); end
    end
    enable = 1'b0;
    tick();
    checks++; if (random !== 16'hEFFB) begin failures++; $display("FAIL step_hold got=%h exp=effb", random); end
  endtask

  task automatic test_load();
    load_state(16'h0000);
    checks++; if (random !== 16'h1FFF) begin failures++; $display("FAIL load_zero got=%h exp=1fff", random); end
    enable = 1'b1;
    load_state(16'hABCD);
    enable = 1'b0;
    checks++; if (random !== 16'hABCD) begin failures++; $display("FAIL load_over_enable got=%h exp=abcd", random); end
  endtask

  task automatic test_zero_limits();
    req = 1'b1; limit = 8'd0;
    tick(); req = 1'b0;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL lim0_early_valid got=%b exp=0", valid); end
    tick();
    checks++; if (valid !== 1'b1 || value !== 8'd0) begin failures++; $display("FAIL lim0_result valid=%b value=%h exp=1,00", valid, value); end
    tick();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL lim0_pulse_width got=%b exp=0", valid); end
    req = 1'b1; limit = 8'd1;
    tick(); req = 1'b0;
    checks++; if (busy !== 1'b1 || valid !== 1'b0) begin failures++; $display("FAIL lim1_busy busy=%b valid=%b exp=1,0", busy, valid); end
    tick();
    checks++; if (busy !== 1'b0 || valid !== 1'b1 || value !== 8'd0) begin failures++; $display("FAIL lim1_result busy=%b valid=%b value=%h exp=0,1,00", busy, valid, value); end
    tick();
  endtask

  task automatic test_accept();
    load_state(16'h0003);
    req = 1'b1; limit = 8'd6;
    tick(); req = 1'b0; limit = 8'd2;   // later limit changes must not matter
    tick();
    checks++; if (valid !== 1'b1 || value !== 8'd3) begin failures++; $display("FAIL accept_first valid=%b value=%0d exp=1,3", valid, value); end
    tick(); tick();
  endtask

  task automatic test_retry();
    logic exp_valid [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic exp_busy  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    load_state(16'h0007);
    req = 1'b1; limit = 8'd6;
    for (int i = 0; i < 4; i++) begin
      tick(); req = 1'b0;
      checks++; if (valid !== exp_valid[i] || busy !== exp_busy[i]) begin failures++; $display("FAIL retry_cycle_%0d valid=%b busy=%b exp=%b,%b", i, valid, busy, exp_valid[i], exp_busy[i]); end
    end
    checks++; if (value !== 8'd4) begin failures++; $display("FAIL retry_value got=%0d exp=4", value); end
    tick();
    checks++; if (valid !== 1'b0 || value !== 8'd4) begin failures++; $display("FAIL retry_hold valid=%b value=%0d exp=0,4", valid, value); end
  endtask

  task automatic test_fallback();
    load_state(16'h0007);
    req = 1'b1; limit = 8'd6;
    tick(); req = 1'b0;
    tick();
    checks++; if (valid2 !== 1'b1 || value2 !== 8'd1) begin failures++; $display("FAIL fallback_value valid=%b value=%0d exp=1,1", valid2, value2); end
    tick(); tick(); tick();
  endtask

  task automatic test_back_to_back();
    logic exp_valid [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic exp_busy  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    req = 1'b1; limit = 8'd1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 4) req = 1'b0;
      checks++; if (valid !== exp_valid[i] || busy !== exp_busy[i]) begin failures++; $display("FAIL b2b_cycle_%0d valid=%b busy=%b exp=%b,%b", i, valid, busy, exp_valid[i], exp_busy[i]); end
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid_sample();
    load_state(16'h0007);
    req = 1'b1; limit = 8'd6;
    tick(); req = 1'b0;
    tick();
    reset = 1'b1;
    tick(); reset = 1'b0;
    checks++; if (valid !== 1'b0 || busy !== 1'b0 || random !== 16'h1FFF) begin failures++; $display("FAIL abort_state valid=%b busy=%b random=%h exp=0,0,1fff", valid, busy, random); end
    tick(); tick();
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_no_pulse valid=%b busy=%b exp=0,0", valid, busy); end
  endtask

  task automatic test_step_count();
    int          adv_cnt = 0;
    int          bad_load = 0;
    int          zero_seen = 0;
    logic [15:0] prev;
    logic [15:0] lv;
    logic        ld;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      prev       = random;
      ld         = ($urandom_range(0, 15) == 0);
      lv         = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
      load       = ld;
      load_value = lv;
      enable     = 1'($urandom_range(0, 1));
      req        = ($urandom_range(0, 3) == 0);
      limit      = 8'($urandom_range(0, 255));
      tick();
      if (!ld && random != prev) adv_cnt++;
      if (ld && random !== ((lv == 16'h0000) ? 16'h1FFF : lv)) bad_load++;
      if (random == 16'h0000) zero_seen++;
    end
    load = 1'b0; enable = 1'b0; req = 1'b0; load_value = '0;
    checks++; if (bad_load != 0) begin failures++; $display("FAIL rand_load_value errors=%0d exp=0", bad_load); end
    checks++; if (zero_seen != 0) begin failures++; $display("FAIL rand_zero_state count=%0d exp=0", zero_seen); end
`ifdef GAME_LFSR_RNG_STEP_COUNT_EN
    checks++; if (step_count !== 32'(adv_cnt)) begin failures++; $display("FAIL step_count got=%0d exp=%0d", step_count, adv_cnt); end
`else
    checks++; if (step_count !== 32'd0) begin failures++; $display("FAIL step_count_tied got=%0d exp=0 (advances=%0d)", step_count, adv_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_step();
    test_load();
    test_zero_limits();
    test_accept();
    test_retry();
    test_fallback();
    test_back_to_back();
    test_reset_mid_sample();
    test_step_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
